// File: rtl/rf_writeback.sv
// ---------------------------------------------------------------------------
// rf_writeback
//
// Merges load results (LSU) and ALU results into a small in-order write
// queue and drains it, one entry per cycle, into a registered register-file
// write port. Pending writes (queued or sitting in the output register) are
// exposed to the operand-read stage through two combinational forwarding
// ports.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   lsu_valid/rd/data/ready    load-result channel (has priority)
//   alu_valid/rd/data/ready    ALU-result channel
//   wb_hold                    stalls the drain while high
//   RFwe, rdaddr, rd           registered register-file write port
//   rs1addr, rs2addr           read addresses to look up
//   rsX_hit, rsX_fwd           forwarding result (youngest matching write)
//   pending                    number of entries currently queued
// ---------------------------------------------------------------------------
module rf_writeback #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4     // power of two, >= 2
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       lsu_valid,
    input  logic [4:0]                 lsu_rd,
    input  logic [XLEN-1:0]            lsu_data,
    output logic                       lsu_ready,

    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    output logic                       alu_ready,

    input  logic                       wb_hold,

    output logic                       RFwe,
    output logic [4:0]                 rdaddr,
    output logic [XLEN-1:0]            rd,

    input  logic [4:0]                 rs1addr,
    input  logic [4:0]                 rs2addr,
    output logic                       rs1_hit,
    output logic [XLEN-1:0]            rs1_fwd,
    output logic                       rs2_hit,
    output logic [XLEN-1:0]            rs2_fwd,

    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_ent_t;

    // -----------------------------------------------------------------------
    // Queue state
    // -----------------------------------------------------------------------
    wb_ent_t          mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    // Output register
    logic             we_q,     we_d;
    logic [4:0]       waddr_q,  waddr_d;
    logic [XLEN-1:0]  wdata_q,  wdata_d;

    // -----------------------------------------------------------------------
    // Accept side
    // -----------------------------------------------------------------------
    logic    full;
    logic    lsu_acc;
    logic    alu_acc;
    logic    push;
    logic    pop;
    wb_ent_t in_ent;

    // Readies look only at the registered count and lsu_valid, so a pop at
    // the same edge cannot open a slot for a full queue.
    assign full      = (cnt_q == CW'(DEPTH));
    assign lsu_ready = !full;
    assign alu_ready = !full && !lsu_valid;

    always_comb begin
        lsu_acc = lsu_valid && lsu_ready;
        alu_acc = alu_valid && alu_ready;
        if (lsu_acc) begin
            in_ent = '{rd: lsu_rd, data: lsu_data};
        end else begin
            in_ent = '{rd: alu_rd, data: alu_data};
        end
        // Writes to x0 complete the handshake but never reach the queue.
        push = (lsu_acc || alu_acc) && (in_ent.rd != 5'd0);
        pop  = (cnt_q != '0) && !wb_hold;
    end

    // -----------------------------------------------------------------------
    // Next-state
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            we_d     = 1'b1;
            waddr_d  = mem_q[rd_ptr_q].rd;
            wdata_d  = mem_q[rd_ptr_q].data;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Storage needs no reset: an entry is only read once the count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_ent;
        end
    end

    assign RFwe    = we_q;
    assign rdaddr  = waddr_q;
    assign rd      = wdata_q;
    assign pending = cnt_q;

    // -----------------------------------------------------------------------
    // Forwarding
    //
    // Priority, oldest first so later matches overwrite earlier ones: output
    // register, then queue entries from head to tail. The entry being
    // accepted this cycle is deliberately not visible.
    // -----------------------------------------------------------------------
    logic [1:0][4:0]      rs_addr;
    logic [1:0]           hit;
    logic [1:0][XLEN-1:0] fwd;

    assign rs_addr = {rs2addr, rs1addr};

    always_comb begin
        hit = '0;
        fwd = '0;
        for (int p = 0; p < 2; p++) begin
            if (rs_addr[p] != 5'd0) begin
                if (we_q && (waddr_q == rs_addr[p])) begin
                    hit[p] = 1'b1;
                    fwd[p] = wdata_q;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if ((CW'(i) < cnt_q) &&
                        (mem_q[rd_ptr_q + AW'(i)].rd == rs_addr[p])) begin
                        hit[p] = 1'b1;
                        fwd[p] = mem_q[rd_ptr_q + AW'(i)].data;
                    end
                end
            end
        end
    end

    assign rs1_hit = hit[0];
    assign rs1_fwd = fwd[0];
    assign rs2_hit = hit[1];
    assign rs2_fwd = fwd[1];

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            lsu_valid, alu_valid, wb_hold;
    logic [4:0]      lsu_rd, alu_rd, rs1addr, rs2addr;
    logic [XLEN-1:0] lsu_data, alu_data;
    logic            lsu_ready, alu_ready, RFwe, rs1_hit, rs2_hit;
    logic [4:0]      rdaddr;
    logic [XLEN-1:0] rd, rs1_fwd, rs2_fwd;
    logic [CW-1:0]   pending;

    rf_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .wb_hold(wb_hold),
        .RFwe(RFwe), .rdaddr(rdaddr), .rd(rd),
        .rs1addr(rs1addr), .rs2addr(rs2addr),
        .rs1_hit(rs1_hit), .rs1_fwd(rs1_fwd), .rs2_hit(rs2_hit), .rs2_fwd(rs2_fwd),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected writes in acceptance order
    typedef struct packed {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t            sb[$];
    ent_t            m_in, m_out;
    int              m_pend = 0;
    logic            m_push, m_pop;
    logic            exp_we = 1'b0;
    logic [4:0]      exp_addr = '0;
    logic [XLEN-1:0] exp_data = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_pend   = 0;
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_data = '0;
        end else begin
            m_pop  = (m_pend > 0) && !wb_hold;
            m_push = 1'b0;
            m_in   = '0;
            if (m_pend != DEPTH) begin
                if (lsu_valid) begin
                    m_in   = '{a: lsu_rd, d: lsu_data};
                    m_push = (lsu_rd != 5'd0);
                end else if (alu_valid) begin
                    m_in   = '{a: alu_rd, d: alu_data};
                    m_push = (alu_rd != 5'd0);
                end
            end
            exp_we = m_pop;
            if (m_pop) begin
                m_out    = sb.pop_front();
                exp_addr = m_out.a;
                exp_data = m_out.d;
            end
            if (m_push) sb.push_back(m_in);
            m_pend = m_pend + int'(m_push) - int'(m_pop);
            #1;
            if (rst_n) begin
                chk("RFwe",    64'(RFwe),    64'(exp_we));
                chk("rdaddr",  64'(rdaddr),  64'(exp_addr));
                chk("rd",      64'(rd),      64'(exp_data));
                chk("pending", 64'(pending), 64'(m_pend));
            end
        end
    end

    initial begin
        rst_n = 1'b0; wb_hold = 1'b0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        rs1addr = 5'd5; rs2addr = 5'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_RFwe",    64'(RFwe),    64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_rdaddr",  64'(rdaddr),  64'd0);
        chk("rst_rd",      64'(rd),      64'd0);
        chk("rst_rs1_hit", 64'(rs1_hit), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);

        // Single ALU write x5 = 0x1234
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        #1 chk("fwd_inflight_hit", 64'(rs1_hit), 64'd0);
        @(negedge clk);
        alu_valid = 1'b0;
        #1 chk("fwd_queue_hit", 64'(rs1_hit), 64'd1);
        chk("fwd_queue_val", rs1_fwd, 64'h1234);
        @(negedge clk);
        #1 chk("fwd_outreg_hit", 64'(rs1_hit), 64'd1);
        chk("fwd_outreg_val", rs1_fwd, 64'h1234);
        @(negedge clk);
        #1 chk("fwd_gone_hit", 64'(rs1_hit), 64'd0);
        chk("fwd_gone_val", rs1_fwd, 64'd0);

        // LSU priority over ALU
        @(negedge clk);
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 64'hA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'hB;
        #1 chk("prio_alu_ready", 64'(alu_ready), 64'd0);
        chk("prio_lsu_ready", 64'(lsu_ready), 64'd1);
        @(negedge clk);
        lsu_valid = 1'b0;
        #1 chk("prio_alu_ready2", 64'(alu_ready), 64'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Fill under hold
        wb_hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(k); alu_data = 64'(k * 16 + 1);
            @(negedge clk);
        end
        alu_valid = 1'b0;
        #1 chk("full_pending",   64'(pending),   64'd4);
        chk("full_lsu_ready",    64'(lsu_ready), 64'd0);
        chk("full_alu_ready",    64'(alu_ready), 64'd0);
        // Releasing the hold while full must not admit a write at that edge
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 64'h99;
        wb_hold = 1'b0;
        #1 chk("full_hold_rel_ready", 64'(lsu_ready), 64'd0);
        @(negedge clk);
        #1 chk("after_pop_ready", 64'(lsu_ready), 64'd1);
        chk("after_pop_pending", 64'(pending), 64'd3);
        @(negedge clk);
        lsu_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1 chk("drained_pending", 64'(pending), 64'd0);

        // x0 discard
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
        @(negedge clk);
        alu_valid = 1'b0;
        #1 chk("x0_pending", 64'(pending), 64'd0);
        repeat (3) @(negedge clk);

        // Youngest-match forwarding
        wb_hold = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h11;
        @(negedge clk);
        alu_data = 64'h22;
        @(negedge clk);
        alu_valid = 1'b0;
        rs1addr = 5'd7; rs2addr = 5'd0;
        #1 chk("fwd7_hit", 64'(rs1_hit), 64'd1);
        chk("fwd7_val",   rs1_fwd, 64'h22);
        chk("fwd_x0_hit", 64'(rs2_hit), 64'd0);
        chk("fwd_x0_val", rs2_fwd, 64'd0);
        rs2addr = 5'd3;
        #1 chk("fwd_miss_hit", 64'(rs2_hit), 64'd0);
        wb_hold = 1'b0;
        @(negedge clk);
        wb_hold = 1'b1;
        #1 chk("fwd_q_over_out_hit", 64'(rs1_hit), 64'd1);
        chk("fwd_q_over_out_val", rs1_fwd, 64'h22);
        wb_hold = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-drain
        wb_hold = 1'b1;
        for (int k = 10; k <= 13; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(k); alu_data = 64'(k * 256);
            @(negedge clk);
        end
        alu_valid = 1'b0;
        wb_hold = 1'b0;
        rs1addr = 5'd11;
        @(negedge clk);
        #1 chk("mid_pending", 64'(pending), 64'd3);
        chk("mid_hit", 64'(rs1_hit), 64'd1);
        rst_n = 1'b0;
        #1 chk("mid_rst_RFwe", 64'(RFwe), 64'd0);
        chk("mid_rst_pending", 64'(pending), 64'd0);
        chk("mid_rst_hit",     64'(rs1_hit), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_rel_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("mid_rel_alu_ready",    64'(alu_ready), 64'd1);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
